// File: rtl/alu_rr_arbiter.sv
// Round-robin front end for one shared, registered ALU: grants one requester per
// cycle, drives its operands to the ALU and steers each result back to its issuer.
module alu_rr_arbiter #(
    parameter int N    = 16,
    parameter int NREQ = 4,
    parameter int LAT  = 1,
    parameter int CW   = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NREQ-1:0]     req_valid,
    output logic [NREQ-1:0]     req_ready,
    input  logic [NREQ*N-1:0]   req_a,
    input  logic [NREQ*N-1:0]   req_b,
    input  logic [NREQ*3-1:0]   req_op,
    output logic [N-1:0]        alu_a,
    output logic [N-1:0]        alu_b,
    output logic [2:0]          alu_op,
    input  logic [N-1:0]        alu_result,
    output logic [NREQ-1:0]     rsp_valid,
    output logic [N-1:0]        rsp_data,
    output logic [CW-1:0]       issue_cnt
);
    localparam int IW = $clog2(NREQ);

    logic [IW-1:0] ptr_reg;
    logic [IW-1:0] ptr_next;
    logic          grant_any;
    logic [IW-1:0] grant_idx;
    logic [CW-1:0] issue_cnt_reg;
    logic          tag_valid_reg [LAT];
    logic [IW-1:0] tag_idx_reg   [LAT];

    // Scan from the farthest offset down so the lowest offset from ptr wins.
    always_comb begin
        int unsigned cand;
        grant_any = 1'b0;
        grant_idx = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            cand = int'(ptr_reg) + k;
            if (cand >= NREQ) begin
                cand = cand - NREQ;
            end
            if (req_valid[cand]) begin
                grant_any = 1'b1;
                grant_idx = IW'(cand);
            end
        end
    end

    always_comb begin
        ptr_next = ptr_reg;
        if (grant_any) begin
            ptr_next = (int'(grant_idx) == NREQ - 1) ? '0 : grant_idx + 1'b1;
        end
    end

    assign alu_a  = grant_any ? req_a[grant_idx*N +: N]  : '0;
    assign alu_b  = grant_any ? req_b[grant_idx*N +: N]  : '0;
    assign alu_op = grant_any ? req_op[grant_idx*3 +: 3] : 3'd0;

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_onehot
        assign req_ready[gi] = grant_any && (grant_idx == IW'(gi));
        assign rsp_valid[gi] = tag_valid_reg[LAT-1] && (tag_idx_reg[LAT-1] == IW'(gi));
    end

    assign rsp_data  = tag_valid_reg[LAT-1] ? alu_result : '0;
    assign issue_cnt = issue_cnt_reg;

    // Tags mirror the ALU pipeline, so reset drops any result still in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_reg       <= '0;
            issue_cnt_reg <= '0;
            for (int s = 0; s < LAT; s++) begin
                tag_valid_reg[s] <= 1'b0;
                tag_idx_reg[s]   <= '0;
            end
        end else begin
            ptr_reg          <= ptr_next;
            tag_valid_reg[0] <= grant_any;
            tag_idx_reg[0]   <= grant_idx;
            for (int s = 1; s < LAT; s++) begin
                tag_valid_reg[s] <= tag_valid_reg[s-1];
                tag_idx_reg[s]   <= tag_idx_reg[s-1];
            end
            if (grant_any) begin
                issue_cnt_reg <= issue_cnt_reg + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Drives two arbiter instances (LAT=1/CW=16 and LAT=3/CW=4) with shared stimulus and
// checks them against a transaction-level model: grant choice, ALU drive, responses, counters.
module tb_alu_rr_arbiter;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  req_valid;
    logic [63:0] req_a, req_b;
    logic [11:0] req_op;

    logic [15:0] in_a [4];
    logic [15:0] in_b [4];
    logic [2:0]  in_op [4];

    logic [3:0]  ready_a, ready_b, rsp_valid_a, rsp_valid_b;
    logic [15:0] alu_a_a, alu_b_a, alu_a_b, alu_b_b, rsp_data_a, rsp_data_b;
    logic [2:0]  alu_op_a, alu_op_b;
    logic [15:0] cnt_a;
    logic [3:0]  cnt_b;
    logic [15:0] result_a;
    logic [15:0] pipe_b [3];

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < 4; gi++) begin : g_pack
        assign req_a[gi*16 +: 16] = in_a[gi];
        assign req_b[gi*16 +: 16] = in_b[gi];
        assign req_op[gi*3 +: 3]  = in_op[gi];
    end

    function automatic logic [15:0] alu_f(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
        case (op)
            3'd0: return a + b;
            3'd1: return a - b;
            3'd2: return a & b;
            3'd3: return a | b;
            default: return 16'h0;
        endcase
    endfunction

    // External registered ALUs seen by each instance.
    always @(posedge clk) begin
        result_a  <= alu_f(alu_op_a, alu_a_a, alu_b_a);
        pipe_b[0] <= alu_f(alu_op_b, alu_a_b, alu_b_b);
        pipe_b[1] <= pipe_b[0];
        pipe_b[2] <= pipe_b[1];
    end

    alu_rr_arbiter #(.N(16), .NREQ(4), .LAT(1), .CW(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(ready_a),
        .req_a(req_a), .req_b(req_b), .req_op(req_op),
        .alu_a(alu_a_a), .alu_b(alu_b_a), .alu_op(alu_op_a), .alu_result(result_a),
        .rsp_valid(rsp_valid_a), .rsp_data(rsp_data_a), .issue_cnt(cnt_a)
    );

    alu_rr_arbiter #(.N(16), .NREQ(4), .LAT(3), .CW(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(ready_b),
        .req_a(req_a), .req_b(req_b), .req_op(req_op),
        .alu_a(alu_a_b), .alu_b(alu_b_b), .alu_op(alu_op_b), .alu_result(pipe_b[2]),
        .rsp_valid(rsp_valid_b), .rsp_data(rsp_data_b), .issue_cnt(cnt_b)
    );

    typedef struct {
        int          due;
        int          idx;
        logic [15:0] data;
    } rsp_t;

    rsp_t q_a[$];
    rsp_t q_b[$];
    int   ptr_m, cnt_m, cyc, last_g;
    int   n_assert, n_fail;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic int model_grant();
        int g;
        g = -1;
        for (int k = 0; k < 4; k++) begin
            if (g < 0 && req_valid[(ptr_m + k) % 4]) g = (ptr_m + k) % 4;
        end
        return g;
    endfunction

    task automatic check_rsp(input string tag, inout rsp_t q[$], input logic [3:0] v, input logic [15:0] d);
        logic [3:0]  ev;
        logic [15:0] ed;
        ev = 4'h0;
        ed = 16'h0;
        if (q.size() > 0 && q[0].due == cyc) begin
            ev = 4'(1 << q[0].idx);
            ed = q[0].data;
            void'(q.pop_front());
        end
        check({tag, "_valid"}, 32'(v), 32'(ev));
        check({tag, "_data"}, 32'(d), 32'(ed));
    endtask

    // One clock: inputs are already set (just after a negedge); returns at the next negedge.
    task automatic cycle();
        int          g;
        logic [15:0] ea, eb, res;
        logic [2:0]  eo;
        #1;
        g  = model_grant();
        ea = (g >= 0) ? in_a[g] : 16'h0;
        eb = (g >= 0) ? in_b[g] : 16'h0;
        eo = (g >= 0) ? in_op[g] : 3'd0;
        check("ready_a", 32'(ready_a), (g >= 0) ? 32'(1 << g) : 32'h0);
        check("ready_b", 32'(ready_b), (g >= 0) ? 32'(1 << g) : 32'h0);
        check("alu_a", 32'(alu_a_a), 32'(ea));
        check("alu_b", 32'(alu_b_a), 32'(eb));
        check("alu_op", 32'(alu_op_a), 32'(eo));
        check_rsp("rsp_a", q_a, rsp_valid_a, rsp_data_a);
        check_rsp("rsp_b", q_b, rsp_valid_b, rsp_data_b);
        check("cnt_a", 32'(cnt_a), 32'(cnt_m % 65536));
        check("cnt_b", 32'(cnt_b), 32'(cnt_m % 16));
        $display("cyc %0d valid=%b grant=%0d ptr=%0d rsp_a=%b rsp_b=%b cnt=%0d",
                 cyc, req_valid, g, ptr_m, rsp_valid_a, rsp_valid_b, cnt_m);
        @(posedge clk);
        if (g >= 0) begin
            res = alu_f(eo, ea, eb);
            q_a.push_back('{cyc + 1, g, res});
            q_b.push_back('{cyc + 3, g, res});
            ptr_m = (g + 1) % 4;
            cnt_m++;
        end
        last_g = g;
        cyc++;
        @(negedge clk);
    endtask

    task automatic set_req(input int i, input bit v, input logic [15:0] a, input logic [15:0] b, input logic [2:0] op);
        req_valid[i] = v;
        in_a[i] = a;
        in_b[i] = b;
        in_op[i] = op;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("rst_rsp_valid_a", 32'(rsp_valid_a), 32'h0);
        check("rst_rsp_valid_b", 32'(rsp_valid_b), 32'h0);
        check("rst_rsp_data_a", 32'(rsp_data_a), 32'h0);
        check("rst_cnt_a", 32'(cnt_a), 32'h0);
        check("rst_cnt_b", 32'(cnt_b), 32'h0);
        req_valid = 4'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        ptr_m = 0;
        cnt_m = 0;
        q_a.delete();
        q_b.delete();
        $display("reset applied at cycle %0d", cyc);
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        cyc      = 0;
        last_g   = -1;
        req_valid = 4'h0;
        for (int i = 0; i < 4; i++) set_req(i, 1'b0, 16'h0, 16'h0, 3'd0);
        @(negedge clk);
        do_reset();

        // Single op on req0: 10 + 20.
        set_req(0, 1'b1, 16'd10, 16'd20, 3'd0);
        cycle();
        req_valid = 4'h0;
        #1;
        check("t1_rsp_valid", 32'(rsp_valid_a), 32'h1);
        check("t1_rsp_data", 32'(rsp_data_a), 32'd30);
        cycle();

        // All four held valid for 8 cycles from ptr=0.
        do_reset();
        set_req(0, 1'b1, 16'd10, 16'd20, 3'd0);
        set_req(1, 1'b1, 16'd50, 16'd3, 3'd1);
        set_req(2, 1'b1, 16'h0F0F, 16'h00FF, 3'd2);
        set_req(3, 1'b1, 16'h0F0F, 16'h00FF, 3'd3);
        repeat (8) cycle();
        req_valid = 4'h0;
        #1;
        check("t2_cnt_a", 32'(cnt_a), 32'd8);
        check("t2_last_rsp", 32'(rsp_valid_a), 32'h8);
        check("t2_last_data", 32'(rsp_data_a), 32'h0FFF);
        cycle();

        // Move ptr to 2, then req1/req3 contend: expect 3, 1, 3.
        req_valid = 4'b0010;
        cycle();
        req_valid = 4'b1010;
        repeat (3) cycle();

        // Idle cycles, then everything valid to confirm ptr held.
        req_valid = 4'h0;
        repeat (4) cycle();
        req_valid = 4'hF;
        cycle();

        // Reset while req2 is being granted: nothing may come back.
        do_reset();
        set_req(2, 1'b1, 16'd7, 16'd5, 3'd0);
        req_valid = 4'b0100;
        #1;
        check("t5_ready", 32'(ready_a), 32'h4);
        #1;
        rst_n = 1'b0;
        #1;
        check("t5_rsp_in_rst", 32'(rsp_valid_a), 32'h0);
        req_valid = 4'h0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        ptr_m = 0;
        cnt_m = 0;
        q_a.delete();
        q_b.delete();
        repeat (5) cycle();
        req_valid = 4'hF;
        #1;
        check("t5_ptr0", 32'(ready_a), 32'h1);
        cycle();

        // Counter wrap on the CW=4 instance and LAT=3 response timing.
        do_reset();
        req_valid = 4'hF;
        repeat (17) cycle();
        req_valid = 4'h0;
        #1;
        check("t6_wrap_b", 32'(cnt_b), 32'd1);
        repeat (4) cycle();

        // Random traffic; a pending ungranted request keeps its fields.
        for (int n = 0; n < 300; n++) begin
            for (int i = 0; i < 4; i++) begin
                if (!(req_valid[i] && last_g != i && $urandom_range(0, 3) != 0)) begin
                    set_req(i, ($urandom_range(0, 9) < 6), 16'($urandom), 16'($urandom),
                            3'($urandom_range(0, 3)));
                end
            end
            cycle();
        end
        req_valid = 4'h0;
        repeat (5) cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
